// File: rtl/anomaly_event_logger.sv
// Timestamped anomaly event FIFO with burst-escalation alarm FSM.
// Optional per-channel event counters: define EVENT_COUNTERS_EN.
module anomaly_event_logger #(
    parameter int NCH          = 4,
    parameter int TS_W         = 16,
    parameter int DEPTH        = 8,
    parameter int WIN          = 64,
    parameter int ALARM_THRESH = 3,
    parameter int HOLD_CYC     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NCH-1:0]            outlier_flags,
    input  logic                      anomaly_pulse,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [TS_W+NCH-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    input  logic                      clr_ovf,
    output logic                      warn,
    output logic                      alarm
`ifdef EVENT_COUNTERS_EN
    ,
    output logic [NCH*16-1:0]         ch_count
`endif
);

    localparam int DW = TS_W + NCH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(WIN);
    localparam int EW = $clog2(ALARM_THRESH + 1);
    localparam int QW = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_WARN, S_ALARM} state_t;

    logic [TS_W-1:0] ts_q, ts_d;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [WW-1:0]   win_q, win_d;
    logic [EW-1:0]   evt_cnt_q, evt_cnt_d, evt_base;
    logic [QW-1:0]   quiet_q, quiet_d;
    state_t          state_q, state_d;
    logic            pop, push, drop, full, win_last;

    always_comb begin
        full     = (cnt_q == CW'(DEPTH));
        pop      = (cnt_q != '0) && rd_ready;
        push     = anomaly_pulse && (!full || pop);
        drop     = anomaly_pulse && full && !pop;
        ts_d     = ts_q + TS_W'(1);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {ts_q, outlier_flags};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // a drop in the same cycle as a clear must leave the flag set
        ovf_d = drop ? 1'b1 : (clr_ovf ? 1'b0 : ovf_q);
    end

    always_comb begin
        win_last  = (win_q == WW'(WIN - 1));
        win_d     = win_last ? '0 : win_q + WW'(1);
        evt_base  = (win_q == '0) ? '0 : evt_cnt_q;
        evt_cnt_d = evt_base;
        if (anomaly_pulse && evt_base != EW'(ALARM_THRESH)) begin
            evt_cnt_d = evt_base + EW'(1);
        end
        quiet_d = '0;
        if (state_q == S_ALARM && !anomaly_pulse) begin
            quiet_d = quiet_q + QW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            win_q     <= '0;
            evt_cnt_q <= '0;
            quiet_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            ts_q      <= ts_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            win_q     <= win_d;
            evt_cnt_q <= evt_cnt_d;
            quiet_q   <= quiet_d;
            mem_q     <= mem_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (anomaly_pulse) state_d = S_WARN;
            end
            S_WARN: begin
                if (evt_cnt_d == EW'(ALARM_THRESH)) state_d = S_ALARM;
                else if (win_last)                 state_d = S_IDLE;
            end
            S_ALARM: begin
                if (!anomaly_pulse && quiet_q == QW'(HOLD_CYC - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        warn       = (state_q == S_WARN);
        alarm      = (state_q == S_ALARM);
        rd_valid   = (cnt_q != '0);
        rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
        fifo_count = cnt_q;
        overflow   = ovf_q;
    end

`ifdef EVENT_COUNTERS_EN
    logic [15:0] ch_cnt_q [NCH];
    logic [15:0] ch_cnt_d [NCH];

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            ch_cnt_d[i] = ch_cnt_q[i];
            if (anomaly_pulse && outlier_flags[i] && ch_cnt_q[i] != 16'hFFFF) begin
                ch_cnt_d[i] = ch_cnt_q[i] + 16'd1;
            end
            ch_count[i*16 +: 16] = ch_cnt_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                ch_cnt_q[i] <= '0;
            end
        end else begin
            ch_cnt_q <= ch_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_anomaly_event_logger.sv
// Directed bench for anomaly_event_logger with a queue-based reference model.
module tb_anomaly_event_logger;

    localparam int DEPTH = 8;
    localparam int WIN   = 64;
    localparam int TH    = 3;
    localparam int HOLD  = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  outlier_flags = '0;
    logic        anomaly_pulse = 1'b0;
    logic        rd_ready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic        rd_valid;
    logic [19:0] rd_data;
    logic [3:0]  fifo_count;
    logic        overflow;
    logic        warn;
    logic        alarm;
`ifdef EVENT_COUNTERS_EN
    logic [63:0] ch_count;
`endif

    always #5 clk = ~clk;

    anomaly_event_logger dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .outlier_flags (outlier_flags),
        .anomaly_pulse (anomaly_pulse),
        .rd_ready      (rd_ready),
        .rd_valid      (rd_valid),
        .rd_data       (rd_data),
        .fifo_count    (fifo_count),
        .overflow      (overflow),
        .clr_ovf       (clr_ovf),
        .warn          (warn),
        .alarm         (alarm)
`ifdef EVENT_COUNTERS_EN
        ,
        .ch_count      (ch_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: event queue, per-window event tally, quiet reference cycle.
    logic [19:0] mq [$];
    bit          m_ovf = 0;
    int          m_st = 0;
    int          c = 0;
    int          win_id = 0;
    int          wcnt = 0;
    int          ref_c = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_ovf  = 0;
                m_st   = 0;
                c      = 0;
                win_id = 0;
                wcnt   = 0;
                ref_c  = 0;
            end else begin
                bit pop, drop;
                pop  = (mq.size() > 0) && rd_ready;
                drop = anomaly_pulse && (mq.size() == DEPTH) && !pop;
                if (pop) void'(mq.pop_front());
                if (anomaly_pulse && !drop) mq.push_back({c[15:0], outlier_flags});
                if (drop) m_ovf = 1;
                else if (clr_ovf) m_ovf = 0;
                if (c / WIN != win_id) begin
                    win_id = c / WIN;
                    wcnt   = 0;
                end
                if (anomaly_pulse && wcnt < TH) wcnt++;
                case (m_st)
                    0: if (anomaly_pulse) m_st = 1;
                    1: begin
                        if (wcnt >= TH) begin
                            m_st  = 2;
                            ref_c = c;
                        end else if (c % WIN == WIN - 1) begin
                            m_st = 0;
                        end
                    end
                    default: begin
                        if (anomaly_pulse) ref_c = c;
                        else if (c - ref_c >= HOLD) m_st = 0;
                    end
                endcase
                c++;
            end
        end
    end

    always @(negedge clk) begin
        chk("m_rd_valid", 32'(rd_valid), 32'(mq.size() > 0));
        chk("m_rd_data", 32'(rd_data), (mq.size() > 0) ? 32'(mq[0]) : 32'd0);
        chk("m_fifo_count", 32'(fifo_count), 32'(mq.size()));
        chk("m_overflow", 32'(overflow), 32'(m_ovf));
        chk("m_warn", 32'(warn), 32'(m_st == 1));
        chk("m_alarm", 32'(alarm), 32'(m_st == 2));
    end

    task automatic step(input logic p, input logic [3:0] f, input logic r, input logic cl);
        anomaly_pulse = p;
        outlier_flags = f;
        rd_ready      = r;
        clr_ovf       = cl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_warn", 32'(warn), 32'd0);
        chk("rst_alarm", 32'(alarm), 32'd0);
        rst_n = 1'b1;

        idle(10);
        step(1'b1, 4'b0101, 1'b0, 1'b0);
        chk("single_valid", 32'(rd_valid), 32'd1);
        chk("single_data", 32'(rd_data), 32'h000A5);
        chk("single_warn", 32'(warn), 32'd1);
        chk("single_count", 32'(fifo_count), 32'd1);
        step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("pop_valid", 32'(rd_valid), 32'd0);
        chk("pop_count", 32'(fifo_count), 32'd0);

        idle(51);
        chk("warn_before_restart", 32'(warn), 32'd1);
        idle(1);
        chk("warn_after_restart", 32'(warn), 32'd0);

        idle(6);
        step(1'b1, 4'h1, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 4'h2, 1'b0, 1'b0);
        chk("burst2_warn", 32'(warn), 32'd1);
        chk("burst2_alarm", 32'(alarm), 32'd0);
        idle(4);
        step(1'b1, 4'h4, 1'b0, 1'b0);
        chk("burst3_alarm", 32'(alarm), 32'd1);
        idle(31);
        chk("quiet31_alarm", 32'(alarm), 32'd1);
        idle(1);
        chk("quiet32_alarm", 32'(alarm), 32'd0);
        chk("quiet32_warn", 32'(warn), 32'd0);

        repeat (3) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("drain_count", 32'(fifo_count), 32'd0);
        for (int i = 0; i < 9; i++) begin
            step(1'b1, i[3:0], 1'b0, 1'b0);
            if (i == 7) begin
                chk("fill8_count", 32'(fifo_count), 32'd8);
                chk("fill8_ovf", 32'(overflow), 32'd0);
            end
        end
        chk("full_count", 32'(fifo_count), 32'd8);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_head", 32'(rd_data), 32'h00740);
        step(1'b1, 4'hA, 1'b1, 1'b0);
        chk("pushpop_count", 32'(fifo_count), 32'd8);
        chk("pushpop_ovf", 32'(overflow), 32'd1);
        chk("pushpop_head", 32'(rd_data), 32'h00751);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 32'd0);
        step(1'b1, 4'hB, 1'b0, 1'b1);
        chk("clr_vs_drop", 32'(overflow), 32'd1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("clr_again", 32'(overflow), 32'd0);

        repeat (8) step(1'b0, 4'h0, 1'b1, 1'b0);
        chk("drain8_count", 32'(fifo_count), 32'd0);
        repeat (3) step(1'b1, 4'h7, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rd_valid", 32'(rd_valid), 32'd0);
        chk("async_rd_data", 32'(rd_data), 32'd0);
        chk("async_count", 32'(fifo_count), 32'd0);
        chk("async_ovf", 32'(overflow), 32'd0);
        chk("async_warn", 32'(warn), 32'd0);
        chk("async_alarm", 32'(alarm), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("post_rst_valid", 32'(rd_valid), 32'd0);

        idle(65534);
        step(1'b1, 4'h3, 1'b0, 1'b0);
        chk("wrap_ffff", 32'(rd_data), 32'hFFFF3);
        step(1'b1, 4'hC, 1'b1, 1'b0);
        chk("wrap_zero", 32'(rd_data), 32'h0000C);
        chk("wrap_count", 32'(fifo_count), 32'd1);

`ifdef EVENT_COUNTERS_EN
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b1, 4'b1001, 1'b1, 1'b0);
        chk("ch0", 32'(ch_count[15:0]), 32'd3);
        chk("ch1", 32'(ch_count[31:16]), 32'd0);
        chk("ch2", 32'(ch_count[47:32]), 32'd0);
        chk("ch3", 32'(ch_count[63:48]), 32'd3);
        dut.ch_cnt_q[0] = 16'hFFFF;
        step(1'b1, 4'b1001, 1'b1, 1'b0);
        chk("ch0_sat", 32'(ch_count[15:0]), 32'hFFFF);
        chk("ch3_inc", 32'(ch_count[63:48]), 32'd4);
`endif

        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
